// File: rtl/router_rd_sink.sv
`default_nettype none
// ============================================================================
// Module  : router_rd_sink
// Brief   : Pops length-prefixed packets from a router output FIFO and checks them.
// Revision: 1.0
// ============================================================================
module router_rd_sink #(
    parameter int         RD_DELAY  = 2,
    parameter logic [1:0] PORT_ADDR = 2'b00,
    parameter int         STALL_MAX = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vld_out,
    input  logic [7:0]  data_out,
    output logic        read_enb,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        pkt_done,
    output logic [5:0]  pkt_len,
    output logic [1:0]  hdr_addr,
    output logic        parity_err,
    output logic        addr_err,
    output logic        trunc_err,
    output logic [15:0] pkt_count
);

    localparam int              c_stall_w   = $clog2(STALL_MAX + 1);
    localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(STALL_MAX - 1);
    localparam logic [4:0]      c_dly_last  = (RD_DELAY > 0) ? 5'(RD_DELAY - 1) : 5'd0;
    localparam bit              c_has_delay = (RD_DELAY > 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [4:0]             r_dly;
    logic [6:0]             r_issued;
    logic [6:0]             w_target;
    logic                   r_cap;
    logic                   r_hdr_got;
    logic [7:0]             r_par;
    logic [7:0]             r_byte;
    logic [5:0]             r_len;
    logic [1:0]             r_addr;
    logic [15:0]            r_cnt;
    logic [c_stall_w-1:0]   r_stall;
    logic                   r_trunc;
    logic                   w_hdr_cap;
    logic                   w_stalled;
    logic                   w_abort;

    assign w_hdr_cap = r_cap & ~r_hdr_got;

    // While the header byte is being captured its length field is used directly,
    // so a zero-length packet never issues a third read.
    always_comb begin
        w_target = 7'd2;
        if (r_hdr_got) begin
            w_target = {1'b0, r_len} + 7'd2;
        end else if (w_hdr_cap) begin
            w_target = {1'b0, data_out[7:2]} + 7'd2;
        end
    end

    assign read_enb  = (r_state == S_READ) && vld_out && (r_issued < w_target);
    assign w_stalled = (r_state == S_READ) && !vld_out && (r_issued < w_target);
    assign w_abort   = w_stalled && (r_stall == c_stall_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (vld_out) begin
                    w_next = c_has_delay ? S_DELAY : S_READ;
                end
            end
            S_DELAY: begin
                if (r_dly == c_dly_last) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (read_enb && ((r_issued + 7'd1) == w_target)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_cap) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dly     <= 5'd0;
            r_issued  <= 7'd0;
            r_cap     <= 1'b0;
            r_hdr_got <= 1'b0;
            r_par     <= 8'd0;
            r_byte    <= 8'd0;
            r_len     <= 6'd0;
            r_addr    <= 2'd0;
            r_cnt     <= 16'd0;
            r_stall   <= '0;
            r_trunc   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cap   <= read_enb;
            r_trunc <= w_abort;
            r_dly   <= (r_state == S_DELAY) ? r_dly + 5'd1 : 5'd0;
            r_stall <= w_stalled ? r_stall + 1'b1 : '0;

            if (r_state == S_IDLE) begin
                r_issued  <= 7'd0;
                r_hdr_got <= 1'b0;
                r_par     <= 8'd0;
            end else begin
                if (read_enb) begin
                    r_issued <= r_issued + 7'd1;
                end
                if (w_hdr_cap) begin
                    r_hdr_got <= 1'b1;
                end
                if (r_cap) begin
                    r_par <= r_par ^ data_out;
                end
            end

            if (r_cap) begin
                r_byte <= data_out;
            end
            if (w_hdr_cap) begin
                r_len  <= data_out[7:2];
                r_addr <= data_out[1:0];
            end
            if (r_state == S_DONE) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // The FIFO presents the popped byte in the cycle after read_enb, so the
    // strobe and the byte are passed straight through in that cycle.
    assign byte_valid = r_cap;
    assign byte_data  = r_cap ? data_out : r_byte;
    assign pkt_done   = (r_state == S_DONE);
    assign parity_err = (r_state == S_DONE) && (r_par != 8'd0);
    assign addr_err   = (r_state == S_DONE) && (r_addr != PORT_ADDR);
    assign trunc_err  = r_trunc;
    assign pkt_len    = r_len;
    assign hdr_addr   = r_addr;
    assign pkt_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_router_rd_sink.sv
`default_nettype none
// Bench for router_rd_sink: FIFO model feeds directed packets, a monitor
// scores every byte strobe, packet completion and truncation.
module tb_router_rd_sink;

    typedef struct {
        logic [5:0]  len;
        logic [1:0]  addr;
        bit          perr;
        bit          aerr;
        logic [15:0] cnt;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vld_out;
    logic [7:0]  data_out = 8'd0;
    logic        read_enb;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        pkt_done;
    logic [5:0]  pkt_len;
    logic [1:0]  hdr_addr;
    logic        parity_err;
    logic        addr_err;
    logic        trunc_err;
    logic [15:0] pkt_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    exp_t       exp_pkt [$];
    logic [7:0] exp_b [$];
    int         exp_trunc = 0;
    logic [15:0] model_cnt = 16'd0;
    logic [7:0] pb [$];
    int         re_cnt = 0;
    int         bv_cnt = 0;

    always #5 clock = ~clock;

    router_rd_sink #(.RD_DELAY(2), .PORT_ADDR(2'b00), .STALL_MAX(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .read_enb   (read_enb),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .hdr_addr   (hdr_addr),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .trunc_err  (trunc_err),
        .pkt_count  (pkt_count)
    );

    // Router output FIFO model: registered read data.
    assign vld_out = (rd_ptr != wr_ptr);
    always @(posedge clock) begin
        if (read_enb) begin
            data_out <= mem[rd_ptr % 1024];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 1024] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Queues expectations for the packet in pb and loads it into the FIFO.
    // split >= 0 lets the FIFO run dry before byte index split for 5+ cycles.
    task automatic issue(input int split, input bit perr, input bit aerr);
        exp_t e;
        e.len  = pb[0][7:2];
        e.addr = pb[0][1:0];
        e.perr = perr;
        e.aerr = aerr;
        e.cnt  = model_cnt;
        model_cnt = model_cnt + 16'd1;
        exp_pkt.push_back(e);
        foreach (pb[i]) exp_b.push_back(pb[i]);
        for (int i = 0; i < pb.size(); i++) begin
            if (i == split) begin
                for (int k = 0; k < 60 && rd_ptr != wr_ptr; k++) @(negedge clock);
                chk("fifo_drain", 32'(rd_ptr == wr_ptr), 32'd1);
                repeat (5) @(negedge clock);
            end
            push_byte(pb[i]);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && exp_pkt.size() != 0; k++) @(negedge clock);
        chk("pkt_timeout", 32'(exp_pkt.size()), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    always @(negedge clock) begin
        logic [7:0] eb;
        exp_t       e;
        if (reset) begin
            re_cnt = 0;
            bv_cnt = 0;
        end else begin
            if (read_enb) re_cnt++;
            if (read_enb && !vld_out) chk("read_without_vld", 32'd1, 32'd0);
            if (byte_valid) begin
                bv_cnt++;
                if (exp_b.size() == 0) begin
                    chk("unexpected_byte", 32'(byte_data), 32'hFFFF_FFFF);
                end else begin
                    eb = exp_b.pop_front();
                    chk("byte_data", 32'(byte_data), 32'(eb));
                end
            end
            if (pkt_done) begin
                if (exp_pkt.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_pkt.pop_front();
                    chk("pkt_len", 32'(pkt_len), 32'(e.len));
                    chk("hdr_addr", 32'(hdr_addr), 32'(e.addr));
                    chk("parity_err", 32'(parity_err), 32'(e.perr));
                    chk("addr_err", 32'(addr_err), 32'(e.aerr));
                    chk("pkt_count_at_done", 32'(pkt_count), 32'(e.cnt));
                    chk("read_cycles", 32'(re_cnt), 32'(e.len) + 32'd2);
                    chk("byte_strobes", 32'(bv_cnt), 32'(e.len) + 32'd2);
                end
                re_cnt = 0;
                bv_cnt = 0;
            end else begin
                chk("err_flags_idle", {30'd0, parity_err, addr_err}, 32'd0);
            end
            if (trunc_err) begin
                if (exp_trunc == 0) begin
                    chk("unexpected_trunc", 32'd1, 32'd0);
                end else begin
                    exp_trunc--;
                end
                re_cnt = 0;
                bv_cnt = 0;
            end
        end
    end

    initial begin
        logic [7:0] p;
        int         start;

        repeat (3) @(negedge clock);
        chk("rst_read_enb", 32'(read_enb), 32'd0);
        chk("rst_outputs", {byte_data, byte_valid, pkt_done, pkt_len, hdr_addr, trunc_err}, 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic packet with delay timing: len 3, addr 0, good parity
        pb = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        issue(-1, 1'b0, 1'b0);
        @(posedge clock); @(negedge clock);
        chk("delay_cycle1", 32'(read_enb), 32'd0);
        @(posedge clock); @(negedge clock);
        chk("delay_cycle2", 32'(read_enb), 32'd0);
        @(posedge clock); @(negedge clock);
        chk("first_read", 32'(read_enb), 32'd1);
        wait_idle();
        chk("pkt_count_1", 32'(pkt_count), 32'd1);

        // Corrupt parity byte
        pb = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0D};
        issue(-1, 1'b1, 1'b0);
        wait_idle();
        chk("pkt_count_2", 32'(pkt_count), 32'd2);

        // Zero-length packet to the wrong port
        pb = '{8'h01, 8'h01};
        issue(-1, 1'b0, 1'b1);
        wait_idle();

        // FIFO runs dry mid-payload for several cycles
        pb = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        issue(3, 1'b0, 1'b0);
        wait_idle();
        chk("pkt_count_4", 32'(pkt_count), 32'd4);

        // Starved mid-packet until the stall limit aborts it
        exp_trunc = 1;
        exp_b.push_back(8'h0C);
        exp_b.push_back(8'h11);
        push_byte(8'h0C);
        push_byte(8'h11);
        for (int k = 0; k < 120 && exp_trunc != 0; k++) @(negedge clock);
        chk("trunc_seen", 32'(exp_trunc), 32'd0);
        repeat (3) @(negedge clock);
        chk("trunc_count_kept", 32'(pkt_count), 32'd4);
        chk("trunc_idle_read", 32'(read_enb), 32'd0);

        // Reset after the second payload byte
        start = rd_ptr;
        pb = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        issue(-1, 1'b0, 1'b0);
        for (int k = 0; k < 40 && rd_ptr != start + 3; k++) @(negedge clock);
        chk("reset_reached", 32'(rd_ptr - start), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_read_enb", 32'(read_enb), 32'd0);
        chk("mid_rst_outputs", {byte_data, byte_valid, pkt_done, pkt_len, hdr_addr, trunc_err}, 32'd0);
        chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
        exp_b.delete();
        exp_pkt.delete();
        model_cnt = 16'd0;
        wr_ptr = rd_ptr;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        pb = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        issue(-1, 1'b0, 1'b0);
        wait_idle();
        chk("post_rst_count", 32'(pkt_count), 32'd1);

        // Maximum length packet
        pb = '{8'hFC};
        p = 8'hFC;
        for (int i = 0; i < 63; i++) begin
            pb.push_back(8'(i * 3 + 1));
            p = p ^ 8'(i * 3 + 1);
        end
        pb.push_back(p);
        issue(-1, 1'b0, 1'b0);
        wait_idle();
        chk("max_pkt_len", 32'(pkt_len), 32'd63);
        chk("max_pkt_count", 32'(pkt_count), 32'd2);
        chk("bytes_left", 32'(exp_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
